a23_cache_flush_ctrl: RTL and testbench

A23_CACHE_FLUSH_CTRL -- requirements
Module: a23_cache_flush_ctrl

---
 rtl/a23_cache_flush_ctrl_pkg.sv | 14 +
 rtl/a23_cache_flush_ctrl.sv | 98 +++++++++
 tb/tb_a23_cache_flush_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a23_cache_flush_ctrl_pkg.sv
// rtl/a23_cache_flush_ctrl_pkg.sv - shared a23 cache flush state encoding and region constants
package a23_cache_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } flush_state_t;

  // Cacheable-area map: one bit per 2 MB region, only the low 64 MB is cacheable.
  localparam int REGION_LSB = 21;
  localparam int REGION_MSB = 25;

endpackage

// File: rtl/a23_cache_flush_ctrl.sv
// rtl/a23_cache_flush_ctrl.sv - tag-RAM invalidate walker for power-up init and CP15 flush
module a23_cache_flush_ctrl
  import a23_cache_flush_ctrl_pkg::*;
#(
  parameter  int CACHE_LINES = 256,
  parameter  int CACHE_WAYS  = 4,
  localparam int IDX_W       = $clog2(CACHE_LINES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cache_enable,
  input  logic                  i_cache_flush,
  input  logic [31:0]           i_cacheable_area,
  input  logic [31:0]           i_address,
  output logic                  o_flushing,
  output logic                  o_stall,
  output logic                  o_tag_wr,
  output logic [CACHE_WAYS-1:0] o_tag_wr_ways,
  output logic [IDX_W-1:0]      o_tag_index,
  output logic                  o_flush_done,
  output logic                  o_cacheable
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CACHE_LINES - 1);

  flush_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tag_wr_q, tag_wr_d;
  logic             flush_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_INIT;
      idx_q    <= '0;
      tag_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // tag_wr_q is low in INIT only for the first cycle after reset, so index 0
  // is presented on the first edge rather than skipped.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tag_wr_d   = tag_wr_q;
    flush_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tag_wr_d = 1'b0;
        idx_d    = '0;
        if (i_cache_flush) begin
          state_d  = ST_FLUSH;
          tag_wr_d = 1'b1;
        end
      end
      ST_INIT, ST_FLUSH: begin
        tag_wr_d = 1'b1;
        if (i_cache_flush) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end else if (!tag_wr_q) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          idx_d      = '0;
          tag_wr_d   = 1'b0;
          flush_done = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_INIT;
        idx_d    = '0;
        tag_wr_d = 1'b0;
      end
    endcase
  end

  assign o_tag_wr      = tag_wr_q;
  assign o_tag_wr_ways = {CACHE_WAYS{tag_wr_q}};
  assign o_tag_index   = idx_q;
  assign o_flush_done  = flush_done;
  assign o_flushing    = (state_q != ST_IDLE);
  assign o_stall       = (state_q != ST_IDLE);

  logic unused_addr_bits;
  assign unused_addr_bits = ^i_address[REGION_LSB-1:0];

  assign o_cacheable = i_cache_enable
                     && (i_address[31:REGION_MSB+1] == '0)
                     && i_cacheable_area[i_address[REGION_MSB:REGION_LSB]]
                     && (state_q == ST_IDLE);

endmodule

// File: tb/tb_a23_cache_flush_ctrl.sv
// tb/tb_a23_cache_flush_ctrl.sv - randomized self-checking bench for a23_cache_flush_ctrl
module tb_a23_cache_flush_ctrl;

  localparam int LINES = 256;
  localparam int WAYS  = 4;

  logic        i_clk;
  logic        i_rst;
  logic        i_cache_enable;
  logic        i_cache_flush;
  logic [31:0] i_cacheable_area;
  logic [31:0] i_address;
  logic        o_flushing;
  logic        o_stall;
  logic        o_tag_wr;
  logic [WAYS-1:0] o_tag_wr_ways;
  logic [7:0]  o_tag_index;
  logic        o_flush_done;
  logic        o_cacheable;

  int total;
  int bad;
  // Walk position: -2 = reset pending (no write yet), -1 = idle, 0..LINES-1 = line being invalidated.
  int pos;

  a23_cache_flush_ctrl #(.CACHE_LINES(LINES), .CACHE_WAYS(WAYS)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_cache_enable   (i_cache_enable),
    .i_cache_flush    (i_cache_flush),
    .i_cacheable_area (i_cacheable_area),
    .i_address        (i_address),
    .o_flushing       (o_flushing),
    .o_stall          (o_stall),
    .o_tag_wr         (o_tag_wr),
    .o_tag_wr_ways    (o_tag_wr_ways),
    .o_tag_index      (o_tag_index),
    .o_flush_done     (o_flush_done),
    .o_cacheable      (o_cacheable)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [15:0] act_vec();
    return {o_tag_wr, o_tag_index, o_tag_wr_ways, o_flush_done, o_stall, o_flushing};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic       walking;
    logic [7:0] idx;
    logic       busy;
    walking = (pos >= 0);
    idx     = walking ? 8'(pos) : 8'd0;
    busy    = (pos != -1);
    return {walking, idx, {WAYS{walking}}, (pos == LINES - 1) && !i_cache_flush, busy, busy};
  endfunction

  function automatic logic exp_cacheable();
    int region;
    if (!i_cache_enable || pos != -1 || i_address >= 32'h0400_0000) return 1'b0;
    region = int'(i_address / 32'h0020_0000);
    return i_cacheable_area[region];
  endfunction

  // Advance one clock edge and step the reference model with the inputs seen at that edge.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst)                         pos = -2;
    else if (pos == -2 || i_cache_flush) pos = 0;
    else if (pos == LINES - 1)         pos = -1;
    else if (pos >= 0)                 pos = pos + 1;
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_cache_flush = 1'b0; i_cache_enable = 1'b0;
    i_cacheable_area = '0; i_address = '0; pos = -2;
    #1;
    total++;
    if (act_vec() !== 16'h0003) begin
      bad++; $display("FAIL reset_values: got %h want %h", act_vec(), 16'h0003);
    end
    for (int k = 0; k < 3; k++) tick();
    i_rst = 1'b0;
    #1;
    for (int k = 0; k < LINES + 2; k++) begin
      tick(); #1;
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_walk k=%0d: got %h want %h", k, act_vec(), exp_vec());
      end
      if (k == 0) begin
        total++;
        if ({o_tag_wr, o_tag_index} !== 9'h100) begin
          bad++; $display("FAIL reset_first_index: got %h want %h", {o_tag_wr, o_tag_index}, 9'h100);
        end
      end
      if (k == LINES - 1) begin
        total++;
        if ({o_flush_done, o_tag_index} !== 9'h1FF) begin
          bad++; $display("FAIL reset_done: got %h want %h", {o_flush_done, o_tag_index}, 9'h1FF);
        end
      end
    end
    total++;
    if (o_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall_release: got %b want 0", o_stall);
    end
  endtask

  task automatic test_idle_flush();
    int wait_n = $urandom_range(1, 5);
    for (int k = 0; k < wait_n; k++) begin
      tick(); #1;
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL idle_wait: got %h want %h", act_vec(), exp_vec());
      end
    end
    i_cache_flush = 1'b1;
    #1;
    total++;
    if ({o_flush_done, o_stall, o_flushing} !== 3'b000) begin
      bad++; $display("FAIL idle_no_comb_stall: got %b want 000", {o_flush_done, o_stall, o_flushing});
    end
    tick();
    i_cache_flush = 1'b0;
    #1;
    total++;
    if ({o_tag_wr, o_tag_index, o_stall} !== 10'b1_0000_0000_1) begin
      bad++; $display("FAIL idle_first_index: got %b want 1000000001", {o_tag_wr, o_tag_index, o_stall});
    end
    for (int k = 1; k < LINES; k++) begin
      tick(); #1;
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL idle_walk k=%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
    total++;
    if ({o_flush_done, o_tag_index} !== 9'h1FF) begin
      bad++; $display("FAIL idle_done: got %h want %h", {o_flush_done, o_tag_index}, 9'h1FF);
    end
    tick(); #1;
    total++;
    if ({o_stall, o_flushing, o_tag_wr, o_flush_done} !== 4'b0000) begin
      bad++; $display("FAIL idle_return: got %b want 0000", {o_stall, o_flushing, o_tag_wr, o_flush_done});
    end
  endtask

  task automatic test_mid_flush();
    int dones = 0;
    i_cache_flush = 1'b1;
    tick();
    i_cache_flush = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    #1;
    total++;
    if (o_tag_index !== 8'd100) begin
      bad++; $display("FAIL mid_reach_100: got %0d want 100", o_tag_index);
    end
    i_cache_flush = 1'b1;
    tick();
    i_cache_flush = 1'b0;
    #1;
    total++;
    if ({o_tag_wr, o_tag_index} !== 9'h100) begin
      bad++; $display("FAIL mid_restart: got %h want %h", {o_tag_wr, o_tag_index}, 9'h100);
    end
    for (int k = 1; k < LINES; k++) begin
      if (o_flush_done === 1'b1) dones++;
      tick(); #1;
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL mid_walk k=%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
    total++;
    if (dones !== 0 || o_flush_done !== 1'b1) begin
      bad++; $display("FAIL mid_done_timing: got early=%0d final=%b want early=0 final=1", dones, o_flush_done);
    end
    tick();
  endtask

  task automatic test_flush_at_last();
    i_cache_flush = 1'b1;
    tick();
    i_cache_flush = 1'b0;
    for (int k = 1; k < LINES; k++) tick();
    i_cache_flush = 1'b1;
    #1;
    total++;
    if ({o_flush_done, o_tag_index} !== 9'h0FF) begin
      bad++; $display("FAIL last_done_suppressed: got %h want %h", {o_flush_done, o_tag_index}, 9'h0FF);
    end
    tick();
    i_cache_flush = 1'b0;
    #1;
    total++;
    if ({o_tag_wr, o_tag_index, o_stall} !== 10'b1_0000_0000_1) begin
      bad++; $display("FAIL last_restart: got %b want 1000000001", {o_tag_wr, o_tag_index, o_stall});
    end
    for (int k = 1; k <= LINES; k++) begin
      tick(); #1;
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL last_walk k=%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    i_cache_flush = 1'b1;
    tick();
    i_cache_flush = 1'b0;
    for (int k = 0; k < 50; k++) tick();
    #2;
    i_rst = 1'b1;
    pos   = -2;
    #1;
    total++;
    if (act_vec() !== 16'h0003) begin
      bad++; $display("FAIL midrst_values: got %h want %h", act_vec(), 16'h0003);
    end
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < LINES + 1; k++) begin
      tick(); #1;
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL midrst_walk k=%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
    total++;
    if (o_stall !== 1'b0) begin
      bad++; $display("FAIL midrst_idle: got %b want 0", o_stall);
    end
  endtask

  task automatic test_cacheable();
    logic [31:0] addrs [4];
    logic        ens   [4];
    logic        wants [4];
    addrs = '{32'h0020_0000, 32'h0000_1000, 32'h0420_0000, 32'h0020_0000};
    ens   = '{1'b1, 1'b1, 1'b1, 1'b0};
    wants = '{1'b1, 1'b0, 1'b0, 1'b0};
    i_cacheable_area = 32'h0000_0002;
    for (int k = 0; k < 4; k++) begin
      i_address = addrs[k]; i_cache_enable = ens[k];
      #1;
      total++;
      if (o_cacheable !== wants[k]) begin
        bad++; $display("FAIL cacheable_dir%0d: got %b want %b", k, o_cacheable, wants[k]);
      end
    end
    for (int k = 0; k < 40; k++) begin
      i_cacheable_area = $urandom();
      i_address        = $urandom() & (k[0] ? 32'hFFFF_FFFF : 32'h07FF_FFFF);
      i_cache_enable   = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (o_cacheable !== exp_cacheable()) begin
        bad++; $display("FAIL cacheable_rand addr=%h: got %b want %b", i_address, o_cacheable, exp_cacheable());
      end
    end
    i_cacheable_area = 32'hFFFF_FFFF; i_address = 32'h0000_0040; i_cache_enable = 1'b1;
    i_cache_flush = 1'b1;
    tick();
    i_cache_flush = 1'b0;
    #1;
    total++;
    if (o_cacheable !== 1'b0) begin
      bad++; $display("FAIL cacheable_during_walk: got %b want 0", o_cacheable);
    end
    for (int k = 0; k < LINES; k++) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      i_cache_flush    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) i_cache_enable = ~i_cache_enable;
      i_cacheable_area = $urandom();
      i_address        = $urandom() & 32'h07FF_FFFF;
      #1;
      total++;
      if (act_vec() !== exp_vec() || o_cacheable !== exp_cacheable()) begin
        bad++; $display("FAIL random k=%0d: got %h/%b want %h/%b", k, act_vec(), o_cacheable, exp_vec(), exp_cacheable());
      end
      tick();
    end
    i_cache_flush = 1'b0;
    for (int k = 0; k < LINES + 2; k++) tick();
    #1;
    total++;
    if (act_vec() !== 16'h0000) begin
      bad++; $display("FAIL random_drain: got %h want %h", act_vec(), 16'h0000);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_idle_flush();
    test_mid_flush();
    test_flush_at_last();
    test_reset_mid_walk();
    test_cacheable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
